spi_flash_read_arbiter: RTL and testbench

- Shares the single SPI flash between the LM32 instruction bus and data bus as two read-only word requesters.
- Issues a standard READ (0x03) transaction, SPI mode 0, for each granted request.
- Sits between the CPU bus adapters and the spi_cs_n/spi_clk/spi_mosi/spi_miso pins of the TinyFPGA SoC top, in the sys_clk domain.

---
 rtl/spi_flash_pkg.sv | 24 ++
 rtl/spi_flash_shifter.sv | 74 +++++++
 rtl/spi_flash_read_arbiter.sv | 115 +++++++++++
 tb/tb_spi_flash_read_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash read arbiter.
// The read frame is {command, 24-bit byte address, 32 dummy bits clocked while data returns}.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        GAP
    } state_e;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_e;

    function automatic logic [FRAME_BITS-1:0] read_frame(input logic [23:0] byte_adr);
        return {CMD_READ, byte_adr, 32'h0};
    endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 bit engine: divides sys_clk into spi_clk, shifts the 64-bit frame out on
// mosi and captures miso into the frame LSB on each spi_clk rising edge.
module spi_flash_shifter
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  done_o,
    output logic [31:0]           data_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shreg_q;
    logic [DIV_W-1:0]      div_q;
    logic [5:0]            bit_q;
    logic                  active_q;
    logic                  sclk_q;
    logic                  mosi_q;

    // NOTE: all state here uses non-blocking assignments so every register sees the
    // pre-edge value of its neighbours, exactly like the flops it describes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else if (start_i) begin
            shreg_q  <= frame_i;
            mosi_q   <= frame_i[FRAME_BITS-1];
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (div_q == DIV_MAX) begin
                div_q <= '0;
                if (!sclk_q) begin
                    sclk_q  <= 1'b1;
                    shreg_q <= {shreg_q[FRAME_BITS-2:0], miso_i};
                end else if (bit_q == BIT_LAST) begin
                    sclk_q   <= 1'b0;
                    mosi_q   <= 1'b0;
                    active_q <= 1'b0;
                end else begin
                    // The shift happened on the rising edge, so the new MSB is the next bit.
                    sclk_q <= 1'b0;
                    mosi_q <= shreg_q[FRAME_BITS-1];
                    bit_q  <= bit_q + 6'd1;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign done_o = active_q && sclk_q && (div_q == DIV_MAX) && (bit_q == BIT_LAST);
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign data_o = shreg_q[31:0];

endmodule

// File: rtl/spi_flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash between the LM32 instruction and data buses,
// issuing one READ frame per granted word request.
module spi_flash_read_arbiter
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CS_IDLE = 2,
    parameter int ADR_W   = 22
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             ibus_req,
    input  logic [ADR_W-1:0] ibus_adr,
    output logic             ibus_ack,
    output logic [31:0]      ibus_dat,
    input  logic             dbus_req,
    input  logic [ADR_W-1:0] dbus_adr,
    output logic             dbus_ack,
    output logic [31:0]      dbus_dat,
    output logic             spi_cs_n,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             busy
);

    localparam int GAP_W = $clog2(CS_IDLE + 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_IDLE - 1);

    state_e            state_q;
    grant_e            grant_q;
    grant_e            prio_q;
    logic [GAP_W-1:0]  gap_q;
    logic              cs_n_q;
    logic              ibus_ack_q;
    logic              dbus_ack_q;

    grant_e            gnt_d;
    logic              start_d;
    logic [ADR_W-1:0]  adr_d;
    logic              shift_done;
    logic [31:0]       rd_data;

    // Round-robin: a lone request wins; on a tie the port not granted last wins.
    assign gnt_d   = (ibus_req && (!dbus_req || prio_q == GRANT_I)) ? GRANT_I : GRANT_D;
    assign start_d = (state_q == IDLE) && (ibus_req || dbus_req);
    assign adr_d   = (gnt_d == GRANT_I) ? ibus_adr : dbus_adr;

    spi_flash_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .start_i (start_d),
        .frame_i (read_frame(24'({adr_d, 2'b00}))),
        .miso_i  (spi_miso),
        .sclk_o  (spi_clk),
        .mosi_o  (spi_mosi),
        .done_o  (shift_done),
        .data_o  (rd_data)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_I;
            prio_q     <= GRANT_I;
            gap_q      <= '0;
            cs_n_q     <= 1'b1;
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        grant_q <= gnt_d;
                        prio_q  <= (gnt_d == GRANT_I) ? GRANT_D : GRANT_I;
                        cs_n_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        cs_n_q     <= 1'b1;
                        ibus_ack_q <= (grant_q == GRANT_I);
                        dbus_ack_q <= (grant_q == GRANT_D);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    ibus_ack_q <= 1'b0;
                    dbus_ack_q <= 1'b0;
                    gap_q      <= GAP_INIT;
                    state_q    <= GAP;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_cs_n = cs_n_q;
    assign ibus_ack = ibus_ack_q;
    assign dbus_ack = dbus_ack_q;
    assign ibus_dat = rd_data;
    assign dbus_dat = rd_data;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Directed bench for spi_flash_read_arbiter with a behavioural READ-only flash model;
// a CLK_DIV=3 instance shares the model through a selector.
module tb_spi_flash_read_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        ibus_req = 1'b0, dbus_req = 1'b0;
    logic [21:0] ibus_adr = '0, dbus_adr = '0;
    logic        ibus_ack, dbus_ack, s1_cs_n, s1_clk, s1_mosi, busy;
    logic [31:0] ibus_dat, dbus_dat;

    logic        i3_req = 1'b0, d3_req = 1'b0;
    logic [21:0] i3_adr = '0, d3_adr = '0;
    logic        i3_ack, d3_ack, s3_cs_n, s3_clk, s3_mosi, busy3;
    logic [31:0] i3_dat, d3_dat;

    logic        sel3 = 1'b0;
    logic        m_cs_n, m_clk, m_mosi, spi_miso;
    logic        override = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int two_acks = 0;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] dat;
    } ack_t;
    ack_t ack_q[$];
    int   fall_q[$];
    int   rise_q[$];

    spi_flash_read_arbiter #(.CLK_DIV(1), .CS_IDLE(2), .ADR_W(22)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .ibus_req(ibus_req), .ibus_adr(ibus_adr), .ibus_ack(ibus_ack), .ibus_dat(ibus_dat),
        .dbus_req(dbus_req), .dbus_adr(dbus_adr), .dbus_ack(dbus_ack), .dbus_dat(dbus_dat),
        .spi_cs_n(s1_cs_n), .spi_clk(s1_clk), .spi_mosi(s1_mosi), .spi_miso(spi_miso),
        .busy(busy)
    );

    spi_flash_read_arbiter #(.CLK_DIV(3), .CS_IDLE(2), .ADR_W(22)) dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .ibus_req(i3_req), .ibus_adr(i3_adr), .ibus_ack(i3_ack), .ibus_dat(i3_dat),
        .dbus_req(d3_req), .dbus_adr(d3_adr), .dbus_ack(d3_ack), .dbus_dat(d3_dat),
        .spi_cs_n(s3_cs_n), .spi_clk(s3_clk), .spi_mosi(s3_mosi), .spi_miso(spi_miso),
        .busy(busy3)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc = cyc + 1;

    assign m_cs_n = sel3 ? s3_cs_n : s1_cs_n;
    assign m_clk  = sel3 ? s3_clk  : s1_clk;
    assign m_mosi = sel3 ? s3_mosi : s1_mosi;

    // Flash model: first 32 rising edges capture command+address, next 32 return data.
    int          edges = 0;
    int          last_edges = 0;
    int          e0 = 0, e1 = 0;
    logic [31:0] cmd = '0;
    logic [31:0] fdata;
    logic [7:0]  b0;

    always @(posedge m_clk or posedge m_cs_n) begin
        if (m_cs_n) begin
            last_edges <= edges;
            edges      <= 0;
        end else begin
            if (edges < 32) cmd <= {cmd[30:0], m_mosi};
            if (edges == 0) e0 <= cyc;
            if (edges == 1) e1 <= cyc;
            edges <= edges + 1;
        end
    end

    assign b0       = cmd[7:0];
    assign fdata    = override ? 32'hDEADBEEF : {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
    assign spi_miso = (edges >= 32 && edges < 64) ? fdata[63 - edges] : 1'b0;

    logic prev_cs = 1'b1;
    always @(negedge sys_clk) begin
        if (ibus_ack === 1'b1) ack_q.push_back('{cyc, 1'b0, ibus_dat});
        if (dbus_ack === 1'b1) ack_q.push_back('{cyc, 1'b1, dbus_dat});
        if (ibus_ack === 1'b1 && dbus_ack === 1'b1) two_acks++;
        if (prev_cs === 1'b1 && s1_cs_n === 1'b0) fall_q.push_back(cyc);
        if (prev_cs === 1'b0 && s1_cs_n === 1'b1) rise_q.push_back(cyc);
        prev_cs = s1_cs_n;
    end

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_q.delete();
        fall_q.delete();
        rise_q.delete();
    endtask

    task automatic wait_acks(input int n, input int limit);
        for (int i = 0; i < limit && ack_q.size() < n; i++) step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && busy !== 1'b0; i++) step();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (3) step();
        sys_rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s1_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", s1_cs_n); end
        checks++; if (s1_clk !== 1'b0) begin errors++; $display("FAIL reset_spi_clk: got %b want 0", s1_clk); end
        checks++; if (s1_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", s1_mosi); end
        checks++; if ({ibus_ack, dbus_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {ibus_ack, dbus_ack}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ibus_dat !== 32'h0) begin errors++; $display("FAIL reset_shreg: got %h want 0", ibus_dat); end
    endtask

    task automatic test_ibus_read();
        int t;
        clear_logs();
        ibus_adr = 22'h000010;
        ibus_req = 1'b1;
        t = cyc;
        wait_acks(1, 400);
        ibus_req = 1'b0;
        checks++;
        if (ack_q.size() != 1) begin
            errors++; $display("FAIL ibus_ack_count: got %0d want 1", ack_q.size());
        end else begin
            checks++; if (ack_q[0].cyc != t + 129) begin errors++; $display("FAIL ibus_latency: got %0d want %0d", ack_q[0].cyc - t, 129); end
            checks++; if (ack_q[0].is_d) begin errors++; $display("FAIL ibus_port: got dbus want ibus"); end
            checks++; if (ack_q[0].dat !== 32'h40414243) begin errors++; $display("FAIL ibus_dat: got %h want 40414243", ack_q[0].dat); end
        end
        checks++; if (cmd !== 32'h03000040) begin errors++; $display("FAIL ibus_mosi: got %h want 03000040", cmd); end
        step();
        checks++; if (ack_q.size() != 1) begin errors++; $display("FAIL ibus_single_ack: got %0d acks want 1", ack_q.size()); end
        checks++; if (last_edges != 64) begin errors++; $display("FAIL ibus_edges: got %0d want 64", last_edges); end
        wait_idle();
    endtask

    task automatic test_dbus_read();
        int t;
        clear_logs();
        override = 1'b1;
        dbus_adr = 22'h000123;
        dbus_req = 1'b1;
        t = cyc;
        wait_acks(1, 400);
        dbus_req = 1'b0;
        checks++;
        if (ack_q.size() != 1) begin
            errors++; $display("FAIL dbus_ack_count: got %0d want 1", ack_q.size());
        end else begin
            checks++; if (ack_q[0].cyc != t + 129) begin errors++; $display("FAIL dbus_latency: got %0d want 129", ack_q[0].cyc - t); end
            checks++; if (!ack_q[0].is_d) begin errors++; $display("FAIL dbus_port: got ibus want dbus"); end
            checks++; if (ack_q[0].dat !== 32'hDEADBEEF) begin errors++; $display("FAIL dbus_dat: got %h want deadbeef", ack_q[0].dat); end
        end
        checks++;
        if (fall_q.size() != 1 || rise_q.size() != 1) begin
            errors++; $display("FAIL dbus_cs_edges: got %0d falls %0d rises want 1 1", fall_q.size(), rise_q.size());
        end else begin
            checks++; if (fall_q[0] != t + 1) begin errors++; $display("FAIL dbus_cs_low_start: got T+%0d want T+1", fall_q[0] - t); end
            checks++; if (rise_q[0] != t + 129) begin errors++; $display("FAIL dbus_cs_low_end: got T+%0d want T+129", rise_q[0] - t); end
        end
        checks++; if (cmd !== 32'h0300048C) begin errors++; $display("FAIL dbus_mosi: got %h want 0300048c", cmd); end
        wait_idle();
        override = 1'b0;
    endtask

    task automatic test_simultaneous();
        int t;
        do_reset();
        clear_logs();
        ibus_adr = 22'h000010;
        dbus_adr = 22'h00003F;
        ibus_req = 1'b1;
        dbus_req = 1'b1;
        t = cyc;
        wait_acks(1, 400);
        ibus_req = 1'b0;
        wait_acks(2, 400);
        dbus_req = 1'b0;
        checks++;
        if (ack_q.size() != 2) begin
            errors++; $display("FAIL sim_ack_count: got %0d want 2", ack_q.size());
        end else begin
            checks++; if (ack_q[0].is_d || ack_q[0].cyc != t + 129) begin errors++; $display("FAIL sim_first: got d=%0d T+%0d want ibus T+129", ack_q[0].is_d, ack_q[0].cyc - t); end
            checks++; if (!ack_q[1].is_d || ack_q[1].cyc != t + 261) begin errors++; $display("FAIL sim_second: got d=%0d T+%0d want dbus T+261", ack_q[1].is_d, ack_q[1].cyc - t); end
            checks++; if (ack_q[1].dat !== 32'hFCFDFEFF) begin errors++; $display("FAIL sim_dbus_dat: got %h want fcfdfeff", ack_q[1].dat); end
        end
        checks++;
        if (fall_q.size() < 2 || rise_q.size() < 1) begin
            errors++; $display("FAIL sim_cs_edges: got %0d falls %0d rises", fall_q.size(), rise_q.size());
        end else begin
            checks++; if (rise_q[0] != t + 129 || fall_q[1] != t + 133) begin errors++; $display("FAIL sim_cs_gap: got high T+%0d..T+%0d want T+129..T+132", rise_q[0] - t, fall_q[1] - t - 1); end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        clear_logs();
        two_acks = 0;
        ibus_adr = 22'h000020;
        dbus_adr = 22'h00003F;
        ibus_req = 1'b1;
        dbus_req = 1'b1;
        wait_acks(6, 1200);
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        checks++;
        if (ack_q.size() != 6) begin
            errors++; $display("FAIL b2b_ack_count: got %0d want 6", ack_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (ack_q[i].is_d != bit'(i % 2)) begin
                    errors++; $display("FAIL b2b_order[%0d]: got d=%0d want d=%0d", i, ack_q[i].is_d, i % 2);
                end
                checks++;
                if (ack_q[i].dat !== ((i % 2) ? 32'hFCFDFEFF : 32'h80818283)) begin
                    errors++; $display("FAIL b2b_dat[%0d]: got %h", i, ack_q[i].dat);
                end
            end
        end
        checks++; if (two_acks != 0) begin errors++; $display("FAIL b2b_two_acks: got %0d want 0", two_acks); end
        wait_idle();
    endtask

    task automatic test_clk_div3();
        int t;
        int ack_cyc = -1;
        logic [31:0] dat = '0;
        sel3 = 1'b1;
        step();
        i3_adr = 22'h000001;
        i3_req = 1'b1;
        t = cyc;
        for (int i = 0; i < 600 && ack_cyc < 0; i++) begin
            step();
            if (i3_ack === 1'b1) begin ack_cyc = cyc; dat = i3_dat; end
        end
        i3_req = 1'b0;
        checks++; if (ack_cyc != t + 385) begin errors++; $display("FAIL div3_latency: got %0d want 385", ack_cyc - t); end
        checks++; if (dat !== 32'h04050607) begin errors++; $display("FAIL div3_dat: got %h want 04050607", dat); end
        checks++; if (last_edges != 64) begin errors++; $display("FAIL div3_edges: got %0d want 64", last_edges); end
        checks++; if (e1 - e0 != 6) begin errors++; $display("FAIL div3_period: got %0d want 6", e1 - e0); end
        checks++; if (cmd !== 32'h03000004) begin errors++; $display("FAIL div3_mosi: got %h want 03000004", cmd); end
        for (int i = 0; i < 20 && busy3 !== 1'b0; i++) step();
        sel3 = 1'b0;
        step();
    endtask

    task automatic test_reset_midframe();
        int t, t2;
        clear_logs();
        ibus_adr = 22'h000010;
        ibus_req = 1'b1;
        t = cyc;
        repeat (41) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        t2 = cyc;
        checks++; if (t2 != t + 42) begin errors++; $display("FAIL rst_timing: got T+%0d want T+42", t2 - t); end
        checks++; if (s1_cs_n !== 1'b1 || s1_clk !== 1'b0) begin errors++; $display("FAIL rst_pins: got cs_n=%b clk=%b want 1 0", s1_cs_n, s1_clk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (ack_q.size() != 0) begin errors++; $display("FAIL rst_no_ack: got %0d acks want 0", ack_q.size()); end
        wait_acks(1, 400);
        ibus_req = 1'b0;
        checks++;
        if (ack_q.size() != 1) begin
            errors++; $display("FAIL rst_restart_ack: got %0d want 1", ack_q.size());
        end else begin
            checks++; if (ack_q[0].cyc != t2 + 129) begin errors++; $display("FAIL rst_restart_latency: got %0d want 129", ack_q[0].cyc - t2); end
            checks++; if (ack_q[0].dat !== 32'h40414243) begin errors++; $display("FAIL rst_restart_dat: got %h want 40414243", ack_q[0].dat); end
        end
        checks++; if (last_edges != 64) begin errors++; $display("FAIL rst_restart_edges: got %0d want 64", last_edges); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_ibus_read();
        test_dbus_read();
        test_simultaneous();
        test_back_to_back();
        test_clk_div3();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
